// File: rtl/pulse_tick_pkg.sv
// pulse_tick_pkg
// Shared definitions for the pulse conditioning block: FSM state encoding
// and default qualification / watchdog constants.
package pulse_tick_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOW    = 2'd0;
  localparam state_t ST_RISE_Q = 2'd1;
  localparam state_t ST_HIGH   = 2'd2;
  localparam state_t ST_FALL_Q = 2'd3;

  localparam int DEF_MIN_HIGH = 3;
  localparam int DEF_MIN_LOW  = 3;
  localparam int DEF_TIMEOUT  = 50000;

endpackage

// File: rtl/pulse_tick_gen_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset asynchronously to 0. Reusable for any external level input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_tick_gen.sv
// pulse_tick_gen
// Conditions an asynchronous pulse pin into single-cycle tick strobes.
// The pin is synchronized, then a four-state filter requires MIN_HIGH
// consecutive high samples to accept a rising edge and MIN_LOW consecutive
// low samples to accept a falling edge. Each accepted rising edge yields
// exactly one registered tick.
// Optional watchdog: build with PULSE_TICK_TIMEOUT_EN defined to get a
// stall flag after TIMEOUT enabled cycles without a tick; otherwise stall
// is tied low and TIMEOUT/TO_W have no effect.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   en    - block enable; low forces the filter idle and outputs low
//   pin   - asynchronous raw pulse input
//   tick  - one-cycle strobe per qualified rising edge
//   level - filtered pin level
//   stall - no tick seen for TIMEOUT enabled cycles
module pulse_tick_gen
  import pulse_tick_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MIN_LOW  = DEF_MIN_LOW,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TO_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic pin,
  output logic tick,
  output logic level,
  output logic stall
);

  // Elaboration-time parameter sanity checks.
  if (MIN_HIGH < 1 || MIN_LOW < 1) begin : g_bad_min
    $error("pulse_tick_gen: MIN_HIGH and MIN_LOW must be >= 1");
  end
  if (longint'(MIN_HIGH) >= (longint'(1) << CNT_W) ||
      longint'(MIN_LOW)  >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("pulse_tick_gen: CNT_W too narrow for MIN_HIGH/MIN_LOW");
  end
  if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << TO_W)) begin : g_bad_to
    $error("pulse_tick_gen: TIMEOUT must be >= 1 and fit in TO_W bits");
  end

  localparam logic [CNT_W-1:0] MH_CNT = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ML_CNT = CNT_W'(MIN_LOW);
  localparam bit               MH_ONE = (MIN_HIGH == 1);
  localparam bit               ML_ONE = (MIN_LOW == 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             qual_rise;
  logic             qual_fall;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin),
    .q     (s)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // A rising edge is accepted this cycle: shared by the FSM (tick) and
  // the watchdog (clear) so both react on the same edge.
  assign qual_rise = en && s &&
                     ((state == ST_LOW    && MH_ONE) ||
                      (state == ST_RISE_Q && cnt_inc == MH_CNT));

  assign qual_fall = en && !s &&
                     ((state == ST_HIGH   && ML_ONE) ||
                      (state == ST_FALL_Q && cnt_inc == ML_CNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOW;
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
    end else if (!en) begin
      state <= ST_LOW;
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
    end else begin
      tick <= qual_rise;
      case (state)
        ST_LOW: begin
          if (qual_rise) begin
            state <= ST_HIGH;
            cnt   <= '0;
            level <= 1'b1;
          end else if (s) begin
            state <= ST_RISE_Q;
            cnt   <= CNT_W'(1);
          end
        end
        ST_RISE_Q: begin
          if (!s) begin
            // Glitch shorter than MIN_HIGH: drop it silently.
            state <= ST_LOW;
            cnt   <= '0;
          end else if (qual_rise) begin
            state <= ST_HIGH;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HIGH: begin
          if (qual_fall) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
          end else if (!s) begin
            state <= ST_FALL_Q;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin // ST_FALL_Q
          if (s) begin
            // Low glitch while high: stay high, no new tick.
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (qual_fall) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

`ifdef PULSE_TICK_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

  logic [TO_W-1:0] wd_cnt;
  logic            stall_r;

  // Watchdog: counts enabled cycles, saturates at TIMEOUT, and is cleared
  // on the same edge that raises tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      stall_r <= 1'b0;
    end else if (!en) begin
      wd_cnt  <= '0;
      stall_r <= 1'b0;
    end else if (qual_rise) begin
      wd_cnt  <= '0;
      stall_r <= 1'b0;
    end else begin
      if (wd_cnt != TO_VAL) begin
        wd_cnt <= wd_cnt + TO_W'(1);
      end
      stall_r <= (wd_cnt == TO_VAL);
    end
  end

  assign stall = stall_r;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_tick_gen.sv
// tb_pulse_tick_gen
// Directed bench for pulse_tick_gen with MIN_HIGH=MIN_LOW=3, TIMEOUT=20.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge following each rising edge.
module tb_pulse_tick_gen;

  localparam int MIN_HIGH = 3;
  localparam int MIN_LOW  = 3;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 20;
  localparam int TO_W     = 8;
  localparam int NVEC     = 36;

  logic clk;
  logic reset;
  logic en;
  logic pin;
  logic tick;
  logic level;
  logic stall;

  int n_pass;
  int n_tot;

  typedef struct {
    logic en;
    logic pin;
    logic exp_tick;
    logic exp_level;
  } vec_t;

  vec_t vecs [NVEC];

  pulse_tick_gen #(
    .MIN_HIGH (MIN_HIGH),
    .MIN_LOW  (MIN_LOW),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .pin   (pin),
    .tick  (tick),
    .level (level),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    int tick_cyc [$];
    logic exp_stall;

    n_pass = 0;
    n_tot  = 0;
    reset  = 1'b1;
    en     = 1'b0;
    pin    = 1'b0;

    // Table: pin high rows 2..11 (tick row 6, level to row 15), a 2-cycle
    // glitch at rows 20..21 (rejected), then a 3-cycle pulse at rows 26..28
    // (tick row 30, level rows 30..32).
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].en        = 1'b1;
      vecs[i].pin       = (i >= 2 && i <= 11) || (i == 20 || i == 21) ||
                          (i >= 26 && i <= 28);
      vecs[i].exp_tick  = (i == 6) || (i == 30);
      vecs[i].exp_level = (i >= 6 && i <= 15) || (i >= 30 && i <= 32);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tick", tick, 1'b0);
    chk("reset_level", level, 1'b0);
    chk("reset_stall", stall, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      en  = vecs[i].en;
      pin = vecs[i].pin;
      step();
      chk($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
    end

    // Square wave 3 high / 3 low, 20 periods
    for (int c = 0; c < 130; c++) begin
      pin = (c < 120) && ((c % 6) < 3);
      step();
      if (tick === 1'b1) tick_cyc.push_back(c);
    end
    chk_int("sq_tick_count", tick_cyc.size(), 20);
    if (tick_cyc.size() > 0) chk_int("sq_first_tick", tick_cyc[0], 4);
    for (int k = 1; k < tick_cyc.size(); k++)
      chk_int($sformatf("sq_spacing%0d", k), tick_cyc[k] - tick_cyc[k-1], 6);

    // Disabled while pin toggles
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pin = c[0];
      step();
      chk($sformatf("dis%0d_tick", c), tick, 1'b0);
      chk($sformatf("dis%0d_level", c), level, 1'b0);
      chk($sformatf("dis%0d_stall", c), stall, 1'b0);
    end
    pin = 1'b1;
    repeat (3) step();
    chk("dis_hold_tick", tick, 1'b0);
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("en_rise%0d_tick", c), tick, c == 3);
      chk($sformatf("en_rise%0d_level", c), level, c >= 3);
    end

    // Reset mid-RISE_Q with cnt=2
    pin = 1'b0;
    repeat (6) step();
    chk("pre_rst_level", level, 1'b0);
    pin = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_tick", tick, 1'b0);
    chk("rst_mid_level", level, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("requal%0d_tick", c), tick, c == 5);
    end
    chk("requal_level", level, 1'b1);

    // Asynchronous reset while level is high
    reset = 1'b1;
    #1;
    chk("rst_high_level", level, 1'b0);
    chk("rst_high_tick", tick, 1'b0);
    @(negedge clk);

    // Watchdog: no edges for TIMEOUT cycles, then one qualified edge
    pin   = 1'b0;
    reset = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      pin = (c >= 22);
      step();
`ifdef PULSE_TICK_TIMEOUT_EN
      exp_stall = (c >= 21 && c <= 25);
`else
      exp_stall = 1'b0;
`endif
      if (c >= 19) chk($sformatf("wd%0d_stall", c), stall, exp_stall);
      if (c >= 24) chk($sformatf("wd%0d_tick", c), tick, c == 26);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule

// File: doc/pulse_tick_gen.md
# pulse_tick_gen

Conditions an asynchronous external pulse input (e.g. a tach or injector sense line) into clean, single-cycle `tick` strobes for the downstream N-bit tick counter. It synchronizes the pin, rejects glitches shorter than a programmable high/low width, and emits exactly one tick per qualified rising edge. An optional watchdog flags a stalled input.

## Interface
- `MIN_HIGH`, default 3: consecutive synchronized high samples required to accept a rising edge; must be >= 1.
- `MIN_LOW`, default 3: consecutive synchronized low samples required to accept a falling edge; must be >= 1.
- `CNT_W`, default 4: filter counter width; must hold `max(MIN_HIGH, MIN_LOW)`.
- `TIMEOUT`, default 50000: enabled cycles without a tick before `stall` asserts; must be >= 1.
- `TO_W`, default 16: watchdog counter width; must hold `TIMEOUT`.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `en`, input, 1: block enable.
- `pin`, input, 1: asynchronous raw pulse input.
- `tick`, output, 1: one-cycle strobe per qualified rising edge.
- `level`, output, 1: filtered pin level.
- `stall`, output, 1: no tick for `TIMEOUT` enabled cycles.

## Operation
- A 2-flop synchronizer on `pin` produces `s`. It runs regardless of `en` and resets to 0.
- The FSM has four states: LOW, RISE_Q, HIGH and FALL_Q. The filter counter is `cnt`.
- LOW:
  - `s=1` with `MIN_HIGH=1`: go to HIGH and assert tick.
  - `s=1` otherwise: go to RISE_Q with `cnt=1`.
  - `s=0`: stay in LOW.
- RISE_Q:
  - `s=0`: go to LOW with `cnt=0`. The glitch is rejected and no tick is produced.
  - `s=1` and `cnt+1==MIN_HIGH`: go to HIGH and assert tick.
  - `s=1` otherwise: increment `cnt`.
- HIGH and FALL_Q mirror LOW and RISE_Q, using `MIN_LOW` and `s=0`. The return to LOW produces no tick.
- `tick` is registered. It is 1 only in the cycle after the transition into HIGH, and is never high on two consecutive cycles.
- `level` is registered. It is 1 while the state is HIGH or FALL_Q.
- `en=0`:
  - State is forced to LOW and `cnt` is forced to 0.
  - `tick`, `level` and `stall` are forced to 0, and the watchdog is cleared.
  - If `pin` is already high when `en` rises, that counts as a rising edge and yields one tick after qualification.
- Reset: all registers go to 0 and the state goes to LOW. `tick`, `level` and `stall` read 0 at reset. Reset asserted mid-qualification discards the partial count.

## Timing
- Let E0 be the first clock edge at which `pin=1` is captured by the first synchronizer flop.
- Held high, the tick asserts after edge E0+MIN_HIGH+1 and stays high for exactly one cycle.
- `level` rises in the same cycle as `tick`.
- `level` falls after edge F0+MIN_LOW+1, where F0 is the first edge capturing `pin=0`.
- Minimum tick spacing is MIN_HIGH+MIN_LOW synchronized samples.
- Watchdog:
  - Counts enabled cycles and clears to 0 in the cycle `tick` is asserted.
  - Saturates at `TIMEOUT`.
  - `stall` is registered and asserts in the cycle after the count reaches `TIMEOUT`.
  - `stall` deasserts in the same cycle a `tick` is output.

## Configuration
- `PULSE_TICK_TIMEOUT_EN` defined: the watchdog counter and `stall` logic are built as described.
- Undefined: no watchdog registers are built, `stall` is tied to 0, and `TIMEOUT`/`TO_W` are ignored.

## Structure
- Shared package `pulse_tick_pkg` holds:
  - state encoding localparams `ST_LOW=2'd0`, `ST_RISE_Q=2'd1`, `ST_HIGH=2'd2`, `ST_FALL_Q=2'd3`;
  - default constants for `MIN_HIGH`, `MIN_LOW` and `TIMEOUT`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async reset to 0, reusable for other external inputs.
- The FSM, filter counter and watchdog live in the top module.

## Test plan
- Reset, `en=1`, `MIN_HIGH=MIN_LOW=3`, `pin` high for 10 cycles -> exactly one tick at E0+4, `level=1` until 4 cycles after `pin` falls.
- `pin` high for 2 cycles, then low -> no tick and `level` stays 0; a following 3-cycle high -> one tick.
- Square wave of 3 cycles high, 3 cycles low, for 20 periods -> 20 ticks, each 1 cycle wide, spaced 6 cycles apart.
- `en=0` while `pin` toggles -> `tick`, `level` and `stall` all 0; raise `en` with `pin` held high -> one tick 3 cycles later.
- With `PULSE_TICK_TIMEOUT_EN` and `TIMEOUT=20`, no edges -> `stall` rises after 20 enabled cycles; next qualified edge -> `stall` clears with the tick. Without the macro -> `stall` stays 0.
- Reset asserted mid-RISE_Q with `cnt=2` -> outputs 0 immediately; after release, `pin` still high -> full 3-sample requalification before a tick.
